// File: rtl/spi_tx_arbiter_pkg.sv
// Shared types and default sizing for the SPI transmit arbiter.
package spi_tx_arbiter_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int DW_DEF      = 12;
  localparam int TIMEOUT_DEF = 4095;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GRANT    = 3'd1,
    ST_LAUNCH   = 3'd2,
    ST_WAIT     = 3'd3,
    ST_COMPLETE = 3'd4
  } state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_tx_arbiter_rr_select.sv
// Round-robin winner search: starts one past last_grant and wraps.
module rr_select
  import spi_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = idx_w(N_REQ_DEF)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic             valid,
  output logic [IW-1:0]    index
);

  int          c;
  logic [IW-1:0] ci;

  always_comb begin
    valid = 1'b0;
    index = last_grant;
    c     = 0;
    ci    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      c  = (int'(last_grant) + k) % N_REQ;
      ci = IW'(c);
      if (!valid && req[ci]) begin
        valid = 1'b1;
        index = ci;
      end
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Shares one SPI transmitter among N_REQ requesters with round-robin
// arbitration, per-slave chip selects and a launch-to-done timeout.
module spi_tx_arbiter
  import spi_tx_arbiter_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    done,
  output logic [N_REQ-1:0]    err,
  output logic                tx_start,
  output logic [DW-1:0]       tx_din,
  input  logic                tx_cs,
  input  logic                tx_done,
  output logic [N_REQ-1:0]    cs_n,
  output logic                busy
);

  localparam int            IW      = idx_w(N_REQ);
  localparam int            CW      = idx_w(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_e           state_q;
  logic [IW-1:0]    grant_q;
  logic [IW-1:0]    last_q;
  logic [CW-1:0]    cnt_q;
  logic [DW-1:0]    hold_q;
  logic [N_REQ-1:0] ack_q, done_q, err_q;
  logic [1:0]       cs_sync_q, done_sync_q;
  logic             rr_vld;
  logic [IW-1:0]    rr_idx;
  logic [DW-1:0]    word [N_REQ];
  logic             xfer;

  for (genvar i = 0; i < N_REQ; i++) begin : g_word
    assign word[i] = req_data[i*DW +: DW];
  end

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  rr_select #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .req        (req),
    .last_grant (last_q),
    .valid      (rr_vld),
    .index      (rr_idx)
  );

  // Each state's action happens on the edge that leaves it, so pulses
  // appear in the cycle following the state that produced them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= IW'(N_REQ - 1);
      cnt_q       <= '0;
      hold_q      <= '0;
      ack_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      cs_sync_q   <= '0;
      done_sync_q <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], tx_cs};
      done_sync_q <= {done_sync_q[0], tx_done};
      ack_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      case (state_q)
        ST_IDLE: begin
          if (rr_vld) begin
            grant_q <= rr_idx;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          hold_q  <= word[grant_q];
          ack_q   <= onehot(grant_q);
          cnt_q   <= '0;
          state_q <= ST_LAUNCH;
        end
        ST_LAUNCH, ST_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          // Abort wins over progress on the cycle the budget runs out.
          if (cnt_q == TO_LAST) begin
            err_q   <= onehot(grant_q);
            last_q  <= grant_q;
            state_q <= ST_IDLE;
          end else if (state_q == ST_LAUNCH && !cs_sync_q[1]) begin
            state_q <= ST_WAIT;
          end else if (state_q == ST_WAIT && done_sync_q[1]) begin
            state_q <= ST_COMPLETE;
          end
        end
        ST_COMPLETE: begin
          done_q  <= onehot(grant_q);
          last_q  <= grant_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign xfer = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);

  // The slave select mirrors the raw transmitter chip-select with no delay.
  always_comb begin
    cs_n = '1;
    if (xfer) cs_n[grant_q] = tx_cs;
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign err      = err_q;
  assign tx_start = (state_q == ST_LAUNCH);
  assign tx_din   = hold_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: table rounds, random rounds vs a rotation model,
// timeout and mid-transfer reset sequences.
module tb_spi_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [47:0] req_data;
  logic [3:0]  ack, done, err, cs_n;
  logic        tx_start, tx_cs, tx_done, busy;
  logic [11:0] tx_din;

  int          checks = 0;
  int          errors = 0;
  int          cur = 0;
  logic [11:0] cur_data = '0;
  int          bench_last = 3;
  bit          xmit_en = 1'b1;

  spi_tx_arbiter #(.N_REQ(4), .DW(12), .TIMEOUT(50)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .done     (done),
    .err      (err),
    .tx_start (tx_start),
    .tx_din   (tx_din),
    .tx_cs    (tx_cs),
    .tx_done  (tx_done),
    .cs_n     (cs_n),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // Slow transmitter: drives on falling edges, drops cs after a start,
  // then raises done (or, when disabled, holds cs until the arbiter aborts).
  initial begin
    tx_cs   = 1'b1;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && tx_cs && rst_n) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        tx_cs = 1'b0;
        if (xmit_en) begin
          repeat ($urandom_range(1, 6)) @(negedge clk);
          tx_done = 1'b1;
          repeat (2) @(negedge clk);
          tx_done = 1'b0;
          tx_cs   = 1'b1;
        end else begin
          for (int k = 0; k < 200 && busy; k++) @(negedge clk);
          tx_cs = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  // Reference: requesters in mask served in rotation starting after last.
  function automatic void rr_order(input logic [3:0] mask, input int last,
                                   output logic [31:0] ord, output int n);
    ord = '0;
    n   = 0;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (mask[c]) begin
        ord = (ord << 4) | 32'(c);
        n++;
      end
    end
  endfunction

  task automatic inv();
    logic [3:0] pulses_ok, exp_cs, inv_oh;
    pulses_ok = {($countones(ack) <= 1), ($countones(done) <= 1),
                 ($countones(err) <= 1), ((done & err) == 4'b0)};
    chk("pulse_onehot", pulses_ok, 4'hF);
    inv_oh = ~oh(cur);
    exp_cs = (busy && !tx_cs) ? inv_oh : 4'hF;
    chk("cs_n", cs_n, exp_cs);
    if (tx_start) chk("tx_din", tx_din, cur_data);
  endtask

  task automatic run_round(input logic [3:0] mask, input logic [11:0] d0,
                           input logic [31:0] ord, input int n, input bit hold);
    logic [11:0] words [4];
    logic [3:0]  e;
    int ai, di, cyc;
    ai = 0; di = 0; cyc = 0;
    for (int i = 0; i < 4; i++) begin
      words[i] = d0 + 12'(i) * 12'h111;
      req_data[i*12 +: 12] = words[i];
    end
    req = mask;
    while ((di < n || busy) && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (ack != 4'b0) begin
        e = 4'b0;
        if (ai < n) e = oh(int'(ord[4*(n-1-ai) +: 4]));
        chk("ack_order", ack, e);
        if (ai == 0) chk("ack_latency", cyc, 2);
        for (int i = 0; i < 4; i++) if (ack[i]) cur = i;
        cur_data = words[cur];
        chk("ack_tx_din", tx_din, cur_data);
        if (!hold) req[cur] = 1'b0;
        ai++;
        if (hold && ai == n) req = 4'b0;
      end
      if (done != 4'b0) begin
        e = 4'b0;
        if (di < n) e = oh(int'(ord[4*(n-1-di) +: 4]));
        chk("done_order", done, e);
        di++;
      end
      chk("err_none", err, 0);
      inv();
    end
    if (cyc >= 400) chk("round_timeout", cyc, 0);
    chk("round_acks", ai, n);
    chk("round_dones", di, n);
    bench_last = cur;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_quiet", {ack, done, err, busy}, 0);
    end
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [11:0] d0;
    logic [31:0] ord;
    int          n;
    bit          hold;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [3:0]  m;
    logic [31:0] ord;
    int          n, k;

    rst_n = 1'b0; req = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pulses", {ack, done, err}, 0);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_din", tx_din, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    tbl[0] = '{4'b1111, 12'h111, 32'h01230, 5, 1'b1};
    tbl[1] = '{4'b0001, 12'hA5C, 32'h0,     1, 1'b0};
    tbl[2] = '{4'b0100, 12'h2B7, 32'h2,     1, 1'b0};
    tbl[3] = '{4'b1010, 12'h4E1, 32'h31,    2, 1'b0};
    tbl[4] = '{4'b1111, 12'h0F0, 32'h2301,  4, 1'b0};
    tbl[5] = '{4'b1001, 12'h7A7, 32'h30,    2, 1'b0};
    tbl[6] = '{4'b0110, 12'h19C, 32'h12,    2, 1'b0};
    tbl[7] = '{4'b1011, 12'hC3D, 32'h301,   3, 1'b0};
    for (int i = 0; i < 8; i++)
      run_round(tbl[i].mask, tbl[i].d0, tbl[i].ord, tbl[i].n, tbl[i].hold);

    for (int r = 0; r < 30; r++) begin
      m = 4'($urandom_range(1, 15));
      rr_order(m, bench_last, ord, n);
      run_round(m, 12'($urandom), ord, n, 1'b0);
    end

    // Transmitter never finishes: abort after TIMEOUT cycles.
    xmit_en = 1'b0;
    req_data[24 +: 12] = 12'h3C3;
    req = 4'b0100;
    k = 0;
    while (ack == 4'b0 && k < 10) begin @(posedge clk); #1; k++; end
    chk("to_ack", ack, 4'b0100);
    req = 4'b0; cur = 2; cur_data = 12'h3C3;
    chk("to_tx_start", tx_start, 1);
    chk("to_tx_din", tx_din, 12'h3C3);
    k = 0;
    while (err == 4'b0 && done == 4'b0 && k < 100) begin
      @(posedge clk); #1; k++; inv();
    end
    chk("to_latency", k, 50);
    chk("to_err", err, 4'b0100);
    chk("to_tx_start_low", tx_start, 0);
    chk("to_busy", busy, 0);
    chk("to_no_done", done, 0);
    repeat (6) begin
      @(posedge clk); #1;
      chk("to_quiet", {done, err}, 0);
    end

    // Reset while waiting for the transmitter.
    req_data[11:0] = 12'h5A5;
    req = 4'b0001;
    k = 0;
    while (ack == 4'b0 && k < 10) begin @(posedge clk); #1; k++; end
    chk("rs_ack", ack, 4'b0001);
    req = 4'b0; cur = 0; cur_data = 12'h5A5;
    k = 0;
    while (tx_start && k < 20) begin @(posedge clk); #1; k++; inv(); end
    @(posedge clk); #1;
    chk("rs_in_wait", {busy, tx_start}, 2'b10);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_cs_n", cs_n, 4'hF);
    chk("rs_tx_start", tx_start, 0);
    chk("rs_busy", busy, 0);
    chk("rs_pulses", {ack, done, err}, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rs_hold_quiet", {ack, done, err, busy}, 0);
    end
    @(negedge clk); rst_n = 1'b1; xmit_en = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("rs_post_quiet", {done, err, busy}, 0);
    end
    run_round(4'b1001, 12'h246, 32'h03, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one SPI transmitter.
REQ-002 Parameter DW, default 12: transmit word width, equal to the transmitter's din width.
REQ-003 Parameter TIMEOUT, default 4095: clk cycles allowed from launch to tx_done before abort.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  level request per requester, held until the matching ack.
REQ-007 req_data  input  N_REQ*DW  word per requester; slice i is bits [i*DW +: DW].
REQ-008 ack  output  N_REQ  one-cycle pulse: requester's word captured; req may drop next cycle.
REQ-009 done  output  N_REQ  one-cycle pulse: that requester's transfer completed.
REQ-010 err  output  N_REQ  one-cycle pulse: that requester's transfer aborted on timeout.
REQ-011 tx_start  output  1  start level to the transmitter.
REQ-012 tx_din  output  DW  word to the transmitter, stable while tx_start is high.
REQ-013 tx_cs  input  1  transmitter chip-select, active low, from the slow SCLK domain.
REQ-014 tx_done  input  1  transmitter done flag, from the slow SCLK domain.
REQ-015 cs_n  output  N_REQ  per-slave chip selects, active low.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 tx_cs and tx_done each pass through a 2-flop synchronizer before any FSM decision.
REQ-018 FSM states: IDLE, GRANT, LAUNCH, WAIT, COMPLETE.
REQ-019 IDLE: if any req bit is high, select a winner by round-robin and go to GRANT; otherwise stay.
REQ-020 Round-robin: search starts at last_grant+1 and wraps modulo N_REQ; first high req wins.
REQ-021 GRANT, one cycle: latch the winner's index and req_data into a holding register, pulse ack[winner], go to LAUNCH.
REQ-022 LAUNCH: drive tx_start=1 and tx_din=holding register; go to WAIT on synchronized tx_cs=0.
REQ-023 WAIT: tx_start=0; go to COMPLETE on synchronized tx_done=1.
REQ-024 COMPLETE, one cycle: pulse done[grant], set last_grant=grant, go to IDLE.
REQ-025 Timeout counter clears on entry to LAUNCH and increments each cycle in LAUNCH and WAIT.
REQ-026 When the timeout counter reaches TIMEOUT: pulse err[grant], drop tx_start, set last_grant=grant, go to IDLE; done is not pulsed.
REQ-027 cs_n[grant] = raw tx_cs (combinational, unsynchronized) in LAUNCH and WAIT; every other cs_n bit, and all bits in other states, are 1.
REQ-028 At most one bit of ack, done, err and cs_n is active in any cycle; done and err never coincide.
REQ-029 req changes after GRANT do not affect the transfer in flight; a requester re-arbitrates only from IDLE.
REQ-030 tx_din holds its last value outside LAUNCH; tx_start is high only in LAUNCH.
REQ-031 Minimum latency: req high to ack is 2 cycles (IDLE decision, GRANT).

Reset
REQ-032 On rst_n=0: state=IDLE, last_grant=N_REQ-1 (requester 0 wins first), counter=0, holding register=0.
REQ-033 On rst_n=0: tx_start=0, ack=0, done=0, err=0, cs_n=all 1, busy=0, synchronizers=0.
REQ-034 Reset mid-transfer aborts immediately and produces no done or err pulse.

Structure
REQ-035 A shared package holds the FSM state enumeration and the default values of N_REQ, DW and TIMEOUT.
REQ-036 The round-robin selector is sub-module rr_select (inputs req and last_grant; outputs valid and index).
REQ-037 The transmitter is instantiated by the parent, not inside this block.

Verification
REQ-038 req=4'b0001, data 12'hA5C, transmitter model completes -> ack[0] 2 cycles after req; tx_din=12'hA5C; cs_n[0] follows tx_cs; done[0] pulses once.
REQ-039 req=4'b1111 held continuously -> grant order 0,1,2,3,0; each requester gets exactly one ack per cycle of grants.
REQ-040 Grant on 2, then only req[1] and req[3] high -> next grant is 3, then 1.
REQ-041 Transmitter model never asserts tx_done, TIMEOUT=50 -> err[grant] pulses 50 cycles after LAUNCH entry; tx_start=0; busy=0 next cycle; no done pulse.
REQ-042 rst_n asserted during WAIT -> cs_n=4'b1111, tx_start=0, busy=0 at once; after release, requester 0 wins first.
REQ-043 req dropped right after ack, during LAUNCH -> transfer still completes and done pulses for that requester.
